// File: rtl/param_stack.sv
// param_stack: parametrised LIFO stack with a registered top-of-stack,
// replace-top (simultaneous push/pop), flush, occupancy count, an
// almost-full threshold and sticky overflow/underflow flags.
//
// Entry k (0 = bottom) is valid for k < COUNT. The storage array is never
// reset. Stale contents cannot leak out because TOS is its own register.
// TOS is loaded only from DATA_WR or from an entry below a valid top.
module param_stack #(
    parameter int DATA_SIZE = 4,
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = 14
) (
    input  logic                          CLK,
    input  logic                          RSTN,
    input  logic                          PUSH,
    input  logic                          POP,
    input  logic                          FLUSH,
    input  logic                          CLR_ERR,
    input  logic [DATA_SIZE-1:0]          DATA_WR,
    output logic [DATA_SIZE-1:0]          TOS,
    output logic [$clog2(DEPTH+1)-1:0]    COUNT,
    output logic                          stack_full,
    output logic                          stack_empty,
    output logic                          almost_full,
    output logic                          overflow,
    output logic                          underflow
);

    // Derived widths: CNT_W holds 0..DEPTH, AW indexes 0..DEPTH-1.
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_LVL);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);

    // Decoded command for this cycle, after priority resolution.
    typedef enum logic [2:0] {
        CMD_IDLE    = 3'd0,
        CMD_FLUSH   = 3'd1,
        CMD_REPLACE = 3'd2,
        CMD_PUSH    = 3'd3,
        CMD_POP     = 3'd4
    } cmd_e;

    cmd_e cmd;

    // Storage and state registers.
    logic [DATA_SIZE-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]     count_q, count_d;
    logic [DATA_SIZE-1:0] tos_q, tos_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;

    // Array write port, computed alongside the next state.
    logic                 mem_we;
    logic [AW-1:0]        mem_waddr;
    logic [DATA_SIZE-1:0] mem_wdata;

    // Useful indices derived from the current count.
    logic [AW-1:0]        push_idx;
    logic [AW-1:0]        top_idx;
    logic [AW-1:0]        below_idx;
    logic                 is_empty;
    logic                 is_full;

    assign is_empty  = (count_q == '0);
    assign is_full   = (count_q == DEPTH_C);
    assign push_idx  = AW'(count_q);
    assign top_idx   = AW'(count_q - ONE_C);
    assign below_idx = AW'(count_q - TWO_C);

    // Resolve the command priority: flush, then replace, then push, then pop.
    always_comb begin
        cmd = CMD_IDLE;
        if (FLUSH) begin
            cmd = CMD_FLUSH;
        end else if (PUSH && POP) begin
            cmd = CMD_REPLACE;
        end else if (PUSH) begin
            cmd = CMD_PUSH;
        end else if (POP) begin
            cmd = CMD_POP;
        end
    end

    // Next-state logic: count, top-of-stack, error flags and array write.
    // Error flags clear first so that a new error in the same cycle wins.
    always_comb begin
        count_d   = count_q;
        tos_d     = tos_q;
        ovf_d     = ovf_q & ~CLR_ERR;
        udf_d     = udf_q & ~CLR_ERR;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = DATA_WR;

        unique case (cmd)
            CMD_FLUSH: begin
                count_d = '0;
                tos_d   = '0;
            end
            CMD_REPLACE: begin
                if (is_empty) begin
                    // The pop half is dropped; the push half still lands.
                    udf_d     = 1'b1;
                    count_d   = ONE_C;
                    tos_d     = DATA_WR;
                    mem_we    = 1'b1;
                    mem_waddr = '0;
                end else begin
                    tos_d     = DATA_WR;
                    mem_we    = 1'b1;
                    mem_waddr = top_idx;
                end
            end
            CMD_PUSH: begin
                if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d   = count_q + ONE_C;
                    tos_d     = DATA_WR;
                    mem_we    = 1'b1;
                    mem_waddr = push_idx;
                end
            end
            CMD_POP: begin
                if (is_empty) begin
                    udf_d = 1'b1;
                end else if (count_q == ONE_C) begin
                    count_d = '0;
                    tos_d   = '0;
                end else begin
                    count_d = count_q - ONE_C;
                    tos_d   = mem_q[below_idx];
                end
            end
            default: begin
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            count_q <= '0;
            tos_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tos_q   <= tos_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage array write; contents are deliberately not reset.
    always_ff @(posedge CLK) begin
        if (RSTN && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign TOS         = tos_q;
    assign COUNT       = count_q;
    assign stack_full  = is_full;
    assign stack_empty = is_empty;
    assign almost_full = (count_q >= AFULL_C);
    assign overflow    = ovf_q;
    assign underflow   = udf_q;

endmodule

// File: doc/param_stack.md
# param_stack

Parametrised LIFO stack, successor to the fixed 2^N-entry stack in the Salamander-4 datapath. Depth need not be a power of two. Top-of-stack is registered and readable without popping. Adds simultaneous push/pop (replace-top), flush, an occupancy count, an almost-full threshold, and sticky overflow/underflow error flags that the control unit polls and clears.

## Interface
- DATA_SIZE, 4, width of one stack entry
- DEPTH, 16, number of entries; legal range 2..256
- AFULL_LVL, 14, almost_full asserts when COUNT >= AFULL_LVL; legal range 1..DEPTH
- CNT_W, $clog2(DEPTH+1), width of COUNT (derived localparam, not overridable)

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- RSTN  in  1  reset, synchronous, active-low
- PUSH  in  1  push DATA_WR this cycle
- POP  in  1  pop top entry this cycle
- FLUSH  in  1  empty the stack this cycle
- CLR_ERR  in  1  clear the sticky error flags
- DATA_WR  in  DATA_SIZE  data to push
- TOS  out  DATA_SIZE  registered top-of-stack; 0 when empty
- COUNT  out  CNT_W  number of valid entries, 0..DEPTH
- stack_full  out  1  COUNT == DEPTH
- stack_empty  out  1  COUNT == 0
- almost_full  out  1  COUNT >= AFULL_LVL
- overflow  out  1  sticky: a push was dropped because the stack was full
- underflow  out  1  sticky: a pop was dropped because the stack was empty

## Operation
- Storage: DEPTH x DATA_SIZE array plus a COUNT register. Entry k (0 = bottom) is valid for k < COUNT. The array is not reset.
- TOS is a register that always equals entry COUNT-1, or 0 when COUNT == 0.
- Command priority per cycle: FLUSH > (PUSH & POP) > PUSH > POP > idle.
- FLUSH: COUNT <- 0, TOS <- 0. PUSH and POP are ignored. Error flags keep their value, apart from CLR_ERR.
- PUSH only, COUNT < DEPTH: write entry COUNT <- DATA_WR, COUNT+1, TOS <- DATA_WR.
- PUSH only, COUNT == DEPTH: no change to storage or COUNT; overflow <- 1.
- POP only, COUNT >= 2: COUNT-1, TOS <- entry COUNT-2.
- POP only, COUNT == 1: COUNT <- 0, TOS <- 0.
- POP only, COUNT == 0: no change; underflow <- 1; TOS stays 0.
- PUSH & POP, COUNT >= 1 (including full): replace top. Entry COUNT-1 <- DATA_WR, TOS <- DATA_WR, COUNT unchanged, no error.
- PUSH & POP, COUNT == 0: the pop is dropped and underflow <- 1. The push executes: COUNT <- 1, TOS <- DATA_WR.
- CLR_ERR clears overflow and underflow. If a new error occurs in the same cycle, that flag is set; set wins over clear.
- COUNT arithmetic is unsigned in CNT_W bits. COUNT never wraps and is always clamped by the rules above.

## Timing
- Reset (RSTN low at a rising edge): COUNT=0, TOS=0, overflow=0, underflow=0. Hence stack_empty=1, stack_full=0, almost_full=0 (AFULL_LVL >= 1). Reset overrides all commands in that cycle.
- Reset asserted mid-sequence discards all contents. Stale array data is never visible on TOS.
- Latency: a command sampled at edge N is reflected on TOS, COUNT, flags and errors immediately after edge N. There is no further pipeline.
- stack_full, stack_empty and almost_full are decoded combinationally from the COUNT register only, never from the inputs. They change only after an edge.
- No handshake or back-pressure. The requester checks stack_full and stack_empty before issuing; a dropped command is reported only through the sticky flags.
- Back-to-back push/pop every cycle is supported at full rate.

## Test plan
- Reset, then 5 pushes of 1,2,3,4,5 (DATA_SIZE=4, DEPTH=5, AFULL_LVL=4) -> TOS follows 1..5; COUNT=5; almost_full from COUNT=4; stack_full after the 5th edge; no errors.
- Full stack, PUSH 9 -> TOS stays 5, COUNT=5, overflow=1 and held. Then CLR_ERR alone -> overflow=0.
- 5 pops from 5,4,3,2,1 -> TOS 4,3,2,1,0; stack_empty=1. 6th pop -> underflow=1, TOS=0, COUNT=0.
- COUNT=3 (top=7), PUSH&POP with DATA_WR=A -> TOS=A, COUNT=3. Next POP -> TOS shows the former second entry.
- Empty stack, PUSH&POP with DATA_WR=6 -> COUNT=1, TOS=6, underflow=1. Same cycle with CLR_ERR=1 -> underflow still 1.
- COUNT=4, FLUSH with PUSH -> COUNT=0, TOS=0. Separately, RSTN low mid-push sequence -> all outputs at reset values on the next cycle.
